// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared command encodings, FSM state type and the
// helper that sizes the strobe-width timer for counter_sequencer.
package counter_seq_pkg;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_RESET   = 2'b01;
    localparam logic [1:0] OP_ADVANCE = 2'b10;
    localparam logic [1:0] OP_RST_ADV = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RST_PULSE,
        RST_GAP,
        ADV_PULSE,
        ADV_GAP,
        FINISH
    } state_t;

    // Timer must hold the larger of the two phase lengths.
    function automatic int timer_w(input int pulse, input int gap);
        int m;
        m = (pulse > gap) ? pulse : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter with a zero flag, used to time the
// pulse and gap phases. Ports: CLK, RST, load, load_val -> zero.
module seq_timer #(
    parameter int W = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: turns RESET/ADVANCE commands into timed counter
// strobes with recovery gaps and keeps a shadow of the external count.
// Ports: CMD_* handshake, ABORT in; ADVANCE_COUNTER, RESET_COUNTER,
// BUSY, DONE, ABORTED, SHADOW_COUNT out. Sync active-high RST.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int COUNT_W      = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [1:0]         CMD_OP,
    input  logic [COUNT_W-1:0] CMD_COUNT,
    input  logic               ABORT,
    output logic               ADVANCE_COUNTER,
    output logic               RESET_COUNTER,
    output logic               BUSY,
    output logic               DONE,
    output logic               ABORTED,
    output logic [COUNT_W-1:0] SHADOW_COUNT
);

    localparam int TW = timer_w(PULSE_CYCLES, GAP_CYCLES);

    // Timer counts from N-1 down to 0 so a phase lasts N cycles.
    localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);

    state_t             state, state_nx;
    logic [1:0]         op_q;
    logic [COUNT_W-1:0] rem_q;
    logic [COUNT_W-1:0] shadow_q;
    logic               abort_q;
    logic               cut_q;
    logic               adv_q;
    logic               rst_q;

    logic               accept;
    logic               abort_now;
    logic               in_seq;
    logic               t_load;
    logic [TW-1:0]      t_val;
    logic               t_zero;
    logic               cut_set;

    assign accept    = CMD_VALID && (state == IDLE);
    // ABORT arriving in the final gap cycle still counts.
    assign abort_now = abort_q || ABORT;
    assign in_seq    = (state == RST_PULSE) || (state == RST_GAP) ||
                       (state == ADV_PULSE) || (state == ADV_GAP);

    seq_timer #(
        .W(TW)
    ) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .load    (t_load),
        .load_val(t_val),
        .zero    (t_zero)
    );

    always_comb begin
        state_nx = state;
        t_load   = 1'b0;
        t_val    = PULSE_LD;
        cut_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (CMD_OP == OP_RESET || CMD_OP == OP_RST_ADV) begin
                        state_nx = RST_PULSE;
                        t_load   = 1'b1;
                    end else if (CMD_OP == OP_ADVANCE &&
                                 CMD_COUNT != '0) begin
                        state_nx = ADV_PULSE;
                        t_load   = 1'b1;
                    end else begin
                        state_nx = FINISH;
                    end
                end
            end
            RST_PULSE: begin
                if (t_zero) begin
                    state_nx = RST_GAP;
                    t_load   = 1'b1;
                    t_val    = GAP_LD;
                end
            end
            RST_GAP: begin
                if (t_zero) begin
                    if (op_q == OP_RST_ADV && rem_q != '0) begin
                        if (abort_now) begin
                            state_nx = FINISH;
                            cut_set  = 1'b1;
                        end else begin
                            state_nx = ADV_PULSE;
                            t_load   = 1'b1;
                        end
                    end else begin
                        state_nx = FINISH;
                    end
                end
            end
            ADV_PULSE: begin
                if (t_zero) begin
                    state_nx = ADV_GAP;
                    t_load   = 1'b1;
                    t_val    = GAP_LD;
                end
            end
            ADV_GAP: begin
                if (t_zero) begin
                    if (rem_q != '0) begin
                        if (abort_now) begin
                            state_nx = FINISH;
                            cut_set  = 1'b1;
                        end else begin
                            state_nx = ADV_PULSE;
                            t_load   = 1'b1;
                        end
                    end else begin
                        state_nx = FINISH;
                    end
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            op_q     <= OP_NOP;
            rem_q    <= '0;
            shadow_q <= '0;
            abort_q  <= 1'b0;
            cut_q    <= 1'b0;
            adv_q    <= 1'b0;
            rst_q    <= 1'b0;
        end else begin
            state <= state_nx;
            // Strobes come straight from flops keyed on next state.
            adv_q <= (state_nx == ADV_PULSE);
            rst_q <= (state_nx == RST_PULSE);
            if (accept) begin
                op_q    <= CMD_OP;
                rem_q   <= CMD_COUNT;
                abort_q <= 1'b0;
                cut_q   <= 1'b0;
            end else begin
                if (in_seq && ABORT) begin
                    abort_q <= 1'b1;
                end
                if (cut_set) begin
                    cut_q <= 1'b1;
                end
            end
            if (state == ADV_PULSE && state_nx == ADV_GAP) begin
                rem_q    <= rem_q - 1'b1;
                shadow_q <= shadow_q + 1'b1;
            end
            if (state == RST_PULSE && state_nx == RST_GAP) begin
                shadow_q <= '0;
            end
        end
    end

    assign CMD_READY       = (state == IDLE);
    assign BUSY            = (state != IDLE);
    assign DONE            = (state == FINISH);
    assign ABORTED         = (state == FINISH) && cut_q;
    assign ADVANCE_COUNTER = adv_q;
    assign RESET_COUNTER   = rst_q;
    assign SHADOW_COUNT    = shadow_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed plus randomized commands checked
// against a timeline model of the strobe/DONE/shadow behaviour.
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    localparam int PW = 4;
    localparam int GW = 4;
    localparam int P  = PW + GW;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        v1 = 1'b0;
    logic [1:0]  op1 = 2'b00;
    logic [15:0] cnt1 = '0;
    logic        ab1 = 1'b0;
    logic        rdy1, adv1, rs1, busy1, done1, abd1;
    logic [15:0] sh1;

    logic        v2 = 1'b0;
    logic [1:0]  op2 = 2'b00;
    logic [3:0]  cnt2 = '0;
    logic        ab2 = 1'b0;
    logic        rdy2, adv2, rs2, busy2, done2, abd2;
    logic [3:0]  sh2;

    int n_cmp = 0;
    int n_bad = 0;
    int m_sh  = 0;

    always #5 CLK = ~CLK;

    counter_sequencer #(
        .PULSE_CYCLES(PW), .GAP_CYCLES(GW), .COUNT_W(16)
    ) u1 (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(v1), .CMD_READY(rdy1),
        .CMD_OP(op1), .CMD_COUNT(cnt1), .ABORT(ab1),
        .ADVANCE_COUNTER(adv1), .RESET_COUNTER(rs1),
        .BUSY(busy1), .DONE(done1), .ABORTED(abd1),
        .SHADOW_COUNT(sh1)
    );

    counter_sequencer #(
        .PULSE_CYCLES(1), .GAP_CYCLES(1), .COUNT_W(4)
    ) u2 (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(v2), .CMD_READY(rdy2),
        .CMD_OP(op2), .CMD_COUNT(cnt2), .ABORT(ab2),
        .ADVANCE_COUNTER(adv2), .RESET_COUNTER(rs2),
        .BUSY(busy2), .DONE(done2), .ABORTED(abd2),
        .SHADOW_COUNT(sh2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one command on u1 and checks every cycle up to the
    // cycle after DONE. ab = cycle in which ABORT is pulsed (0 = none).
    task automatic run_cmd(input logic [1:0] op, input int cnt,
                           input int ab);
        int rf, planned, dn, dc, upto, sh_start, sh, j, off;
        logic cut, e_adv, e_rst;
        rf = (op == OP_RESET || op == OP_RST_ADV) ? 1 : 0;
        planned = rf;
        if (op == OP_ADVANCE || op == OP_RST_ADV) planned += cnt;
        dn = planned;
        if (ab > 0) begin
            upto = (ab - 1) / P + 1;
            if (upto < planned) dn = upto;
        end
        cut = (dn < planned);
        dc = 1 + dn * P;
        sh_start = m_sh;
        chk("ready_before_accept", 32'(rdy1), 32'd1);
        v1   = 1'b1;
        op1  = op;
        cnt1 = 16'(cnt);
        ab1  = 1'($urandom_range(0, 1));
        for (int c = 1; c <= dc + 1; c++) begin
            @(negedge CLK);
            v1   = 1'b0;
            op1  = 2'($urandom);
            cnt1 = 16'($urandom);
            e_adv = 1'b0;
            e_rst = 1'b0;
            if (c < dc) begin
                j   = (c - 1) / P;
                off = (c - 1) % P;
                if (off < PW) begin
                    if (rf == 1 && j == 0) e_rst = 1'b1;
                    else e_adv = 1'b1;
                end
            end
            sh = sh_start;
            for (int k = 0; k < dn; k++) begin
                if (k * P + PW < c) begin
                    if (rf == 1 && k == 0) sh = 0;
                    else sh = (sh + 1) % 65536;
                end
            end
            chk($sformatf("outs op%0d n%0d c%0d", op, cnt, c),
                32'({adv1, rs1, done1, busy1, rdy1, abd1}),
                32'({e_adv, e_rst, 1'(c == dc), 1'(c <= dc),
                     1'(c > dc), 1'(c == dc && cut)}));
            chk($sformatf("shadow op%0d n%0d c%0d", op, cnt, c),
                32'(sh1), 32'(sh));
            ab1 = (c == ab);
        end
        ab1 = 1'b0;
        m_sh = sh;
    endtask

    initial begin
        int ops, nn, abc, seen, dcyc;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("reset_u1",
            32'({rdy1, adv1, rs1, busy1, done1, abd1}), 32'b100000);
        chk("reset_u1_shadow", 32'(sh1), 32'd0);
        chk("reset_u2",
            32'({rdy2, adv2, rs2, busy2, done2, abd2, sh2}),
            32'b1000000000);
        RST = 1'b0;
        @(negedge CLK);

        run_cmd(OP_ADVANCE, 3, 0);
        run_cmd(OP_RST_ADV, 3, 0);
        run_cmd(OP_ADVANCE, 0, 0);
        run_cmd(OP_NOP, 0, 0);
        run_cmd(OP_ADVANCE, 10, 10);
        run_cmd(OP_RESET, 0, 0);
        run_cmd(OP_RST_ADV, 0, 0);
        run_cmd(OP_RST_ADV, 4, 3);

        for (int i = 0; i < 14; i++) begin
            ops = $urandom_range(0, 3);
            nn  = $urandom_range(0, 4);
            abc = 0;
            if ($urandom_range(0, 2) == 0)
                abc = $urandom_range(1, 1 + 5 * P);
            run_cmd(2'(ops), nn, abc);
        end

        // Synchronous reset while a pulse is in flight.
        v1 = 1'b1; op1 = OP_ADVANCE; cnt1 = 16'd5;
        @(negedge CLK);
        v1 = 1'b0;
        @(negedge CLK);
        chk("midrst_pulse_high", 32'(adv1), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_outs",
            32'({adv1, rs1, done1, busy1, rdy1, abd1}), 32'b000010);
        chk("midrst_shadow", 32'(sh1), 32'd0);
        RST = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (done1 || adv1 || rs1 || busy1) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        m_sh = 0;

        // Narrow instance: max count, then wrap with VALID held high.
        v2 = 1'b1; op2 = OP_ADVANCE; cnt2 = 4'd15;
        @(negedge CLK);
        v2 = 1'b0;
        dcyc = 0;
        for (int c = 1; c <= 40 && dcyc == 0; c++) begin
            if (done2) dcyc = c;
            else @(negedge CLK);
        end
        chk("u2_max_done_cycle", 32'(dcyc), 32'd31);
        chk("u2_max_shadow", 32'(sh2), 32'd15);
        @(negedge CLK);
        chk("u2_ready_after", 32'(rdy2), 32'd1);
        v2 = 1'b1; op2 = OP_ADVANCE; cnt2 = 4'd2;
        seen = 0;
        dcyc = 0;
        for (int c = 1; c <= 20 && dcyc == 0; c++) begin
            @(negedge CLK);
            if (adv2) seen++;
            if (c == 2) chk("u2_wrap0", 32'(sh2), 32'd0);
            if (c == 4) chk("u2_wrap1", 32'(sh2), 32'd1);
            if (done2) begin
                dcyc = c;
                v2 = 1'b0;
            end
        end
        chk("u2_wrap_done_cycle", 32'(dcyc), 32'd5);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (adv2 || busy2) seen++;
        end
        chk("u2_single_accept", 32'(seen), 32'd2);
        chk("u2_final_shadow", 32'(sh2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven sequencer for the counter-IC control path. It accepts reset/advance commands from the tester FSM over a valid/ready handshake and generates correctly timed ADVANCE_COUNTER / RESET_COUNTER strobes for the downstream counter-control block. Every strobe is held for the required width and followed by a recovery gap. It keeps a shadow copy of the external counter value so the tester can read the expected count without sampling the ICs.

## Interface
Parameters:
- PULSE_CYCLES, 4, strobe high time in CLK cycles (40 ns at 100 MHz); legal range ≥1
- GAP_CYCLES, 4, strobe low time after each pulse before the next strobe or DONE; legal range ≥1
- COUNT_W, 16, width of CMD_COUNT and SHADOW_COUNT

Ports:
- CLK  in  1  system clock, 100 MHz
- RST  in  1  synchronous, active-high reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  sequencer can accept a command; high only in IDLE
- CMD_OP  in  2  00 NOP, 01 RESET, 10 ADVANCE, 11 RESET_THEN_ADVANCE
- CMD_COUNT  in  COUNT_W  number of advance pulses (ignored for RESET/NOP)
- ABORT  in  1  request early termination of the current command
- ADVANCE_COUNTER  out  1  strobe to counter control, advance
- RESET_COUNTER  out  1  strobe to counter control, reset
- BUSY  out  1  high from the cycle after acceptance until DONE inclusive
- DONE  out  1  single-cycle completion pulse
- ABORTED  out  1  valid with DONE; high if the command was cut short
- SHADOW_COUNT  out  COUNT_W  expected external counter value

## Operation
- Handshake: a command is accepted on the CLK edge where CMD_VALID && CMD_READY. CMD_OP and CMD_COUNT are latched at that edge. Inputs are don't-care otherwise.
- States: IDLE, RST_PULSE, RST_GAP, ADV_PULSE, ADV_GAP, FINISH.
- Transitions out of IDLE on accept:
  - RESET or RESET_THEN_ADVANCE → RST_PULSE
  - ADVANCE with count>0 → ADV_PULSE
  - NOP, or ADVANCE with count=0 → FINISH
- RST_PULSE: RESET_COUNTER=1 for PULSE_CYCLES, then → RST_GAP.
- RST_GAP: lasts GAP_CYCLES. Afterwards → ADV_PULSE if the op is RESET_THEN_ADVANCE and count>0; otherwise → FINISH.
- ADV_PULSE: ADVANCE_COUNTER=1 for PULSE_CYCLES, then → ADV_GAP. The remaining-pulse counter decrements on entry to ADV_GAP.
- ADV_GAP: lasts GAP_CYCLES. Afterwards → ADV_PULSE if remaining>0, else → FINISH.
- FINISH: DONE=1 for one cycle, then → IDLE.
- The two strobes are never high simultaneously. Strobes are registered outputs, glitch-free.
- SHADOW_COUNT:
  - cleared to 0 on the RST_PULSE → RST_GAP edge
  - incremented by 1 on each ADV_PULSE → ADV_GAP edge
  - wraps modulo 2^COUNT_W
  - holds otherwise
- ABORT is sampled every cycle while BUSY. It sets a sticky abort flag that is cleared on accept.
  - A pulse in progress is never truncated.
  - At the end of the current gap the FSM goes to FINISH instead of starting another pulse; DONE and ABORTED are asserted together.
  - ABORT in IDLE or FINISH is ignored.
- Reset mid-operation: all outputs return to reset values on the next edge, strobes drop immediately, and no DONE is issued.

## Timing
- Reset values: CMD_READY=1, ADVANCE_COUNTER=0, RESET_COUNTER=0, BUSY=0, DONE=0, ABORTED=0, SHADOW_COUNT=0; state IDLE.
- Acceptance at edge 0 → first strobe high in cycle 1.
- Each pulse+gap occupies PULSE_CYCLES+GAP_CYCLES cycles.
- DONE cycle = 1 + k·(PULSE_CYCLES+GAP_CYCLES), where k = total strobes issued. For zero strobes, DONE is in cycle 1.
- CMD_READY is low from cycle 1 through the DONE cycle. It returns high in the cycle after DONE, so back-to-back commands have one idle cycle minimum.
- Remaining-pulse counter is COUNT_W bits. CMD_COUNT = 2^COUNT_W−1 is legal.

## Structure
- Package counter_seq_pkg holds:
  - CMD_OP encodings (OP_NOP, OP_RESET, OP_ADVANCE, OP_RST_ADV)
  - state enum
  - timer width function ($clog2 of max(PULSE_CYCLES, GAP_CYCLES)+1)
- One sub-module, seq_timer: loadable down-counter with a zero flag, reloaded with PULSE_CYCLES or GAP_CYCLES on state entry. The FSM, pulse counter and shadow counter live in counter_sequencer.

## Test plan
- After RST: ADVANCE with CMD_COUNT=3, defaults → ADVANCE_COUNTER high cycles 1–4, 9–12, 17–20; DONE in cycle 25; SHADOW_COUNT=3.
- RESET_THEN_ADVANCE with count=3 after the previous test → RESET_COUNTER high cycles 1–4; SHADOW_COUNT=0 at cycle 5; three advance pulses follow; DONE in cycle 33; SHADOW_COUNT=3.
- ADVANCE with count=0, and NOP → no strobes; DONE in cycle 1; CMD_READY high in cycle 2; SHADOW_COUNT unchanged.
- ADVANCE with count=10 and ABORT pulsed in cycle 10 (during the second pulse) → second pulse completes full width; no third pulse; DONE+ABORTED in cycle 17; SHADOW_COUNT=2.
- RST asserted during ADV_PULSE → strobes 0 and CMD_READY=1 at the next edge; no DONE; SHADOW_COUNT=0.
- COUNT_W=4, SHADOW_COUNT=15, ADVANCE count=2 → SHADOW_COUNT wraps to 0 then 1; CMD_VALID held high with CMD_READY low is not accepted twice.
